// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator between the EX/MEM stage and a word-wide,
// big-endian data memory. Handles one request at a time. Sub-word stores are done
// as a read-modify-write with a one-cycle dm_req gap between the read and the write.
module mem_access_ctrl #(
   parameter int DEPTH_WORDS = 13,
   parameter int ADDR_W      = 4,
   parameter int TIMEOUT     = 15
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_signed,
   input  logic [31:0]       i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_resp_valid,
   output logic [31:0]       o_resp_rdata,
   output logic              o_resp_misalign,
   output logic              o_resp_error,
   output logic              o_stall,
   output logic              o_dm_req,
   output logic              o_dm_we,
   output logic [ADDR_W-1:0] o_dm_addr,
   output logic [31:0]       o_dm_wdata,
   input  logic [31:0]       i_dm_rdata,
   input  logic              i_dm_ack
);

   localparam int               CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [29:0]      DEPTH_IDX = 30'(DEPTH_WORDS);

   // S_GAP is the idle cycle between the read and write halves of a read-modify-write
   typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP, S_WR, S_RESP} state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic                r_we;
   logic [1:0]          r_size;
   logic                r_signed;
   logic [1:0]          r_lane;
   logic [15:0]         r_wdata_lo;
   logic [ADDR_W-1:0]   r_dm_addr;
   logic [31:0]         r_dm_wdata;
   logic [31:0]         r_rdata;
   logic                r_misalign;
   logic                r_error;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_accept;
   logic                w_misalign;
   logic                w_range_err;
   logic                w_sub_store;
   logic                w_expired;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load_data;
   logic [31:0]         w_merge_word;

   assign w_accept    = i_req_valid & (r_state == S_IDLE);
   assign w_range_err = (i_req_addr[31:2] >= DEPTH_IDX);
   assign w_sub_store = r_we & (r_size != 2'b10);
   // Last allowed wait cycle; an ack in this same cycle still wins
   assign w_expired   = (r_cnt == CNT_LAST);

   // Alignment check on the incoming request; size 11 is always rejected
   always_comb begin
      w_misalign = 1'b0;
      case (i_req_size)
         2'b01:   w_misalign = i_req_addr[0];
         2'b10:   w_misalign = |i_req_addr[1:0];
         2'b11:   w_misalign = 1'b1;
         default: w_misalign = 1'b0;
      endcase
   end

   // Big-endian lane extraction for loads and lane replacement for sub-word stores
   always_comb begin
      w_byte = i_dm_rdata[31:24];
      case (r_lane)
         2'd1:    w_byte = i_dm_rdata[23:16];
         2'd2:    w_byte = i_dm_rdata[15:8];
         2'd3:    w_byte = i_dm_rdata[7:0];
         default: w_byte = i_dm_rdata[31:24];
      endcase
      w_half = r_lane[1] ? i_dm_rdata[15:0] : i_dm_rdata[31:16];

      w_load_data = i_dm_rdata;
      if (r_size == 2'b00) begin
         w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      end else if (r_size == 2'b01) begin
         w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      end

      w_merge_word = i_dm_rdata;
      if (r_size == 2'b00) begin
         case (r_lane)
            2'd1:    w_merge_word[23:16] = r_wdata_lo[7:0];
            2'd2:    w_merge_word[15:8]  = r_wdata_lo[7:0];
            2'd3:    w_merge_word[7:0]   = r_wdata_lo[7:0];
            default: w_merge_word[31:24] = r_wdata_lo[7:0];
         endcase
      end else if (r_lane[1]) begin
         w_merge_word[15:0] = r_wdata_lo;
      end else begin
         w_merge_word[31:16] = r_wdata_lo;
      end
   end

   // Next-state and state-decoded handshake outputs
   always_comb begin
      w_state_next = r_state;
      o_req_ready  = 1'b0;
      o_dm_req     = 1'b0;
      o_dm_we      = 1'b0;
      o_resp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req_ready = 1'b1;
            if (w_accept) begin
               if (w_misalign | w_range_err) begin
                  w_state_next = S_RESP;
               end else if (i_req_we && (i_req_size == 2'b10)) begin
                  w_state_next = S_WR;
               end else begin
                  w_state_next = S_RD;
               end
            end
         end
         S_RD: begin
            o_dm_req = 1'b1;
            if (i_dm_ack) begin
               w_state_next = w_sub_store ? S_GAP : S_RESP;
            end else if (w_expired) begin
               w_state_next = S_RESP;
            end
         end
         S_GAP: begin
            w_state_next = S_WR;
         end
         S_WR: begin
            o_dm_req = 1'b1;
            o_dm_we  = 1'b1;
            if (i_dm_ack || w_expired) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            o_resp_valid = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign o_resp_misalign = o_resp_valid & r_misalign;
   assign o_resp_error    = o_resp_valid & r_error;
   assign o_resp_rdata    = r_rdata;
   assign o_dm_addr       = r_dm_addr;
   assign o_dm_wdata      = r_dm_wdata;
   assign o_stall         = i_req_valid & ~o_resp_valid & ((r_state != S_IDLE) | w_accept);

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Request capture, memory data path, result and timeout counter
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_signed   <= 1'b0;
         r_lane     <= 2'b00;
         r_wdata_lo <= 16'h0;
         r_dm_addr  <= '0;
         r_dm_wdata <= 32'h0;
         r_rdata    <= 32'h0;
         r_misalign <= 1'b0;
         r_error    <= 1'b0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we       <= i_req_we;
                  r_size     <= i_req_size;
                  r_signed   <= i_req_signed;
                  r_lane     <= i_req_addr[1:0];
                  r_wdata_lo <= i_req_wdata[15:0];
                  r_dm_addr  <= i_req_addr[ADDR_W+1:2];
                  r_dm_wdata <= i_req_wdata;
                  r_rdata    <= 32'h0;
                  r_misalign <= w_misalign;
                  r_error    <= ~w_misalign & w_range_err;
                  r_cnt      <= '0;
               end
            end
            S_RD: begin
               if (i_dm_ack) begin
                  if (w_sub_store) begin
                     r_dm_wdata <= w_merge_word;
                  end else begin
                     r_rdata <= w_load_data;
                  end
               end else if (w_expired) begin
                  r_error <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_GAP: begin
               r_cnt <= '0;
            end
            S_WR: begin
               if (!i_dm_ack) begin
                  if (w_expired) begin
                     r_error <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: drives directed and random requests, models the memory with a
// programmable ack delay, and checks every cycle of each transaction against a
// timeline and result computed from byte-addressed arithmetic on a reference memory.
module tb_mem_access_ctrl;

   localparam int DEPTH = 13;
   localparam int AW    = 4;
   localparam int TO    = 15;
   localparam int NEVER = 1000;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          i_reset      = 1'b0;
   logic          i_req_valid  = 1'b0;
   logic          i_req_we     = 1'b0;
   logic [1:0]    i_req_size   = 2'b00;
   logic          i_req_signed = 1'b0;
   logic [31:0]   i_req_addr   = 32'h0;
   logic [31:0]   i_req_wdata  = 32'h0;
   logic [31:0]   i_dm_rdata   = 32'h0;
   logic          i_dm_ack     = 1'b0;
   logic          o_req_ready;
   logic          o_resp_valid;
   logic [31:0]   o_resp_rdata;
   logic          o_resp_misalign;
   logic          o_resp_error;
   logic          o_stall;
   logic          o_dm_req;
   logic          o_dm_we;
   logic [AW-1:0] o_dm_addr;
   logic [31:0]   o_dm_wdata;

   mem_access_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .i_clk           (clk),
      .i_reset         (i_reset),
      .i_req_valid     (i_req_valid),
      .o_req_ready     (o_req_ready),
      .i_req_we        (i_req_we),
      .i_req_size      (i_req_size),
      .i_req_signed    (i_req_signed),
      .i_req_addr      (i_req_addr),
      .i_req_wdata     (i_req_wdata),
      .o_resp_valid    (o_resp_valid),
      .o_resp_rdata    (o_resp_rdata),
      .o_resp_misalign (o_resp_misalign),
      .o_resp_error    (o_resp_error),
      .o_stall         (o_stall),
      .o_dm_req        (o_dm_req),
      .o_dm_we         (o_dm_we),
      .o_dm_addr       (o_dm_addr),
      .o_dm_wdata      (o_dm_wdata),
      .i_dm_rdata      (i_dm_rdata),
      .i_dm_ack        (i_dm_ack)
   );

   logic [31:0]   mem     [DEPTH];
   logic [31:0]   ref_mem [DEPTH];
   int            errors = 0;
   int            checks = 0;
   int            ack_delay = 0;
   bit            spurious_en = 0;

   bit            tx_on = 0;
   int            tx_cyc = 0;
   int            exp_resp_cyc = 0;
   bit            exp_req [64];
   bit            exp_we  [64];
   logic [31:0]   exp_rdata;
   logic [31:0]   exp_wdata;
   logic [AW-1:0] exp_addr;
   bit            exp_mis;
   bit            exp_err;
   logic [31:0]   obs_rdata;
   int            obs_resp_cyc;
   bit            obs_mis;
   bit            obs_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference memory viewed as bytes, big-endian within each word
   function automatic logic [31:0] byte_at(input logic [31:0] a);
      logic [31:0] w;
      w = ref_mem[int'(a >> 2)];
      return (w >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n, input logic sgn);
      logic [31:0] v;
      v = 32'h0;
      for (int k = 0; k < n; k++) v = (v << 8) | byte_at(addr + 32'(k));
      if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] addr, input int n, input logic [31:0] wdata);
      logic [31:0] a;
      logic [31:0] b;
      int          sh;
      int          idx;
      for (int k = 0; k < n; k++) begin
         a   = addr + 32'(k);
         b   = (wdata >> (8 * (n - 1 - k))) & 32'hFF;
         sh  = 8 * (3 - int'(a[1:0]));
         idx = int'(a >> 2);
         ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | (b << sh);
      end
   endtask

   // Memory responder: acks after ack_delay wait cycles, random ack noise while idle
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[2] = 32'hBC0019D4;
      mem[3] = 32'hACD50000;
      forever begin
         @(negedge clk);
         if (o_dm_req && int'(o_dm_addr) < DEPTH && wait_cnt >= ack_delay) begin
            i_dm_ack   = 1'b1;
            i_dm_rdata = mem[int'(o_dm_addr)];
            if (o_dm_we) mem[int'(o_dm_addr)] = o_dm_wdata;
            wait_cnt = 0;
         end else if (o_dm_req) begin
            i_dm_ack   = 1'b0;
            i_dm_rdata = $urandom;
            wait_cnt++;
         end else begin
            i_dm_ack   = spurious_en && ($urandom_range(3) == 0);
            i_dm_rdata = $urandom;
            wait_cnt   = 0;
         end
      end
   end

   // Per-cycle comparison against the expected transaction timeline
   always @(negedge clk) begin
      if (tx_on && tx_cyc < 64) begin
         chk("req_ready", 32'(o_req_ready), 32'(tx_cyc == 0 || tx_cyc > exp_resp_cyc));
         chk("resp_valid", 32'(o_resp_valid), 32'(tx_cyc == exp_resp_cyc));
         chk("stall", 32'(o_stall), 32'(i_req_valid && tx_cyc < exp_resp_cyc));
         chk("dm_req", 32'(o_dm_req), 32'(exp_req[tx_cyc]));
         chk("dm_we", 32'(o_dm_we), 32'(exp_we[tx_cyc]));
         if (exp_req[tx_cyc]) chk("dm_addr", 32'(o_dm_addr), 32'(exp_addr));
         if (exp_we[tx_cyc]) chk("dm_wdata", o_dm_wdata, exp_wdata);
         if (tx_cyc == exp_resp_cyc) begin
            chk("resp_rdata", o_resp_rdata, exp_rdata);
            chk("resp_misalign", 32'(o_resp_misalign), 32'(exp_mis));
            chk("resp_error", 32'(o_resp_error), 32'(exp_err));
         end
         if (o_resp_valid) begin
            obs_resp_cyc = tx_cyc;
            obs_rdata    = o_resp_rdata;
            obs_mis      = o_resp_misalign;
            obs_err      = o_resp_error;
         end
      end
   end

   // One complete request; called at 1 time unit after a rising edge
   task automatic run_tx(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int d);
      int   n;
      bit   mis;
      bit   rng;
      int   resp;
      n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      mis = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
      rng = !mis && (addr[31:2] >= 30'(DEPTH));
      for (int k = 0; k < 64; k++) begin
         exp_req[k] = 1'b0;
         exp_we[k]  = 1'b0;
      end
      exp_rdata = 32'h0;
      exp_wdata = 32'h0;
      exp_mis   = mis;
      exp_err   = rng;
      exp_addr  = addr[AW+1:2];
      if (mis || rng) begin
         resp = 1;
      end else if (d >= TO) begin
         resp    = TO + 1;
         exp_err = 1'b1;
         for (int k = 1; k <= TO; k++) exp_req[k] = 1'b1;
      end else if (!we) begin
         resp = 2 + d;
         for (int k = 1; k <= 1 + d; k++) exp_req[k] = 1'b1;
         exp_rdata = ref_load(addr, n, sgn);
      end else if (size == 2'b10) begin
         resp = 2 + d;
         for (int k = 1; k <= 1 + d; k++) begin
            exp_req[k] = 1'b1;
            exp_we[k]  = 1'b1;
         end
         ref_store(addr, n, wdata);
         exp_wdata = ref_mem[int'(addr >> 2)];
      end else begin
         resp = 4 + 2 * d;
         for (int k = 1; k <= 1 + d; k++) exp_req[k] = 1'b1;
         for (int k = 3 + d; k <= 3 + 2 * d; k++) begin
            exp_req[k] = 1'b1;
            exp_we[k]  = 1'b1;
         end
         ref_store(addr, n, wdata);
         exp_wdata = ref_mem[int'(addr >> 2)];
      end
      exp_resp_cyc = resp;
      obs_resp_cyc = -1;
      obs_rdata    = 32'h0;
      obs_mis      = 1'b0;
      obs_err      = 1'b0;
      ack_delay    = d;

      i_req_valid  = 1'b1;
      i_req_we     = we;
      i_req_size   = size;
      i_req_signed = sgn;
      i_req_addr   = addr;
      i_req_wdata  = wdata;
      tx_cyc       = 0;
      tx_on        = 1'b1;
      for (int c = 1; c <= resp + 1; c++) begin
         @(posedge clk);
         #1;
         tx_cyc       = c;
         i_req_valid  = (c <= resp);
         i_req_we     = 1'($urandom_range(1));
         i_req_size   = 2'($urandom_range(3));
         i_req_signed = 1'($urandom_range(1));
         i_req_addr   = $urandom;
         i_req_wdata  = $urandom;
      end
      @(posedge clk);
      #1;
      tx_on = 1'b0;
      $display("tx we=%0d size=%0d signed=%0d addr=%08h wdata=%08h delay=%0d -> resp_cyc=%0d rdata=%08h mis=%0d err=%0d",
               we, size, sgn, addr, wdata, d, obs_resp_cyc, obs_rdata, obs_mis, obs_err);
   endtask

   // Abandon a sub-word store by resetting while its write phase is waiting for ack
   task automatic reset_mid_rmw();
      bit seen;
      seen         = 1'b0;
      ack_delay    = 3;
      spurious_en  = 1'b0;
      i_req_valid  = 1'b1;
      i_req_we     = 1'b1;
      i_req_size   = 2'b00;
      i_req_signed = 1'b0;
      i_req_addr   = 32'd14;
      i_req_wdata  = 32'h00000077;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         if (o_dm_we) seen = 1'b1;
      end
      chk("rst_reach_write", 32'(seen), 32'd1);
      i_reset     = 1'b0;
      i_req_valid = 1'b0;
      @(negedge clk);
      chk("rst_dm_req", 32'(o_dm_req), 32'd0);
      chk("rst_req_ready", 32'(o_req_ready), 32'd1);
      chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
      i_reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_after_resp_valid", 32'(o_resp_valid), 32'd0);
         chk("rst_after_dm_req", 32'(o_dm_req), 32'd0);
      end
      chk("rst_word_untouched", mem[3], 32'hAC5A0000);
      $display("tx reset during write phase of byte store to addr 0000000e");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r_we;
      logic [1:0]  r_size;
      logic [31:0] r_addr;
      int          r_d;
      int          r_n;
      int          pick;

      i_reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", 32'(o_req_ready), 32'd1);
      chk("reset_dm_req", 32'(o_dm_req), 32'd0);
      chk("reset_dm_we", 32'(o_dm_we), 32'd0);
      chk("reset_resp_valid", 32'(o_resp_valid), 32'd0);
      chk("reset_misalign", 32'(o_resp_misalign), 32'd0);
      chk("reset_error", 32'(o_resp_error), 32'd0);
      chk("reset_rdata", o_resp_rdata, 32'd0);
      chk("reset_dm_addr", 32'(o_dm_addr), 32'd0);
      chk("reset_dm_wdata", o_dm_wdata, 32'd0);
      chk("reset_stall", 32'(o_stall), 32'd0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
      @(posedge clk);
      #1;
      i_reset = 1'b1;

      // Directed cases with literal expectations
      run_tx(1'b0, 2'b00, 1'b1, 32'd8, 32'h0, 0);
      chk("lit_lb_signed", obs_rdata, 32'hFFFFFFBC);
      chk("lit_load_latency", 32'(obs_resp_cyc), 32'd2);
      run_tx(1'b0, 2'b01, 1'b0, 32'd10, 32'h0, 0);
      chk("lit_lhu", obs_rdata, 32'h000019D4);
      run_tx(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 0);
      chk("lit_lw", obs_rdata, 32'hBC0019D4);
      run_tx(1'b1, 2'b00, 1'b0, 32'd13, 32'hFFFFFF5A, 0);
      chk("lit_sb_latency", 32'(obs_resp_cyc), 32'd4);
      run_tx(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 0);
      chk("lit_after_sb", obs_rdata, 32'hAC5A0000);
      run_tx(1'b0, 2'b01, 1'b0, 32'd9, 32'h0, 0);
      chk("lit_misalign", 32'(obs_mis), 32'd1);
      chk("lit_misalign_latency", 32'(obs_resp_cyc), 32'd1);
      run_tx(1'b0, 2'b10, 1'b0, 32'd52, 32'h0, 0);
      chk("lit_range_err", 32'(obs_err), 32'd1);
      run_tx(1'b0, 2'b11, 1'b0, 32'd4, 32'h0, 0);
      chk("lit_illegal_size", 32'(obs_mis), 32'd1);
      run_tx(1'b0, 2'b10, 1'b0, 32'd48, 32'h0, 0);
      run_tx(1'b0, 2'b10, 1'b0, 32'hFFFFFFF0, 32'h0, 0);
      run_tx(1'b1, 2'b10, 1'b0, 32'd20, 32'h13579BDF, 0);
      run_tx(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, NEVER);
      chk("lit_timeout_err", 32'(obs_err), 32'd1);
      chk("lit_timeout_latency", 32'(obs_resp_cyc), 32'(TO + 1));
      run_tx(1'b1, 2'b01, 1'b0, 32'd22, 32'h00001234, NEVER);
      run_tx(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, TO - 1);
      chk("lit_last_chance_ok", 32'(obs_err), 32'd0);
      run_tx(1'b0, 2'b00, 1'b0, 32'd9, 32'h0, 3);
      run_tx(1'b1, 2'b01, 1'b0, 32'd6, 32'h0000BEEF, TO - 1);
      reset_mid_rmw();

      // Randomized traffic
      for (int t = 0; t < 150; t++) begin
         r_we = 1'($urandom_range(1));
         pick = $urandom_range(9);
         r_size = (pick < 4) ? 2'b00 : (pick < 7) ? 2'b01 : (pick < 9) ? 2'b10 : 2'b11;
         r_n = (r_size == 2'b00) ? 1 : (r_size == 2'b01) ? 2 : 4;
         pick = $urandom_range(9);
         if (pick == 0) r_addr = $urandom;
         else if (pick == 1) r_addr = 32'(DEPTH * 4 + $urandom_range(15));
         else r_addr = 32'($urandom_range(DEPTH * 4 - 1));
         if ($urandom_range(3) != 0) r_addr = r_addr & ~32'(r_n - 1);
         pick = $urandom_range(9);
         if (pick < 6) r_d = $urandom_range(3);
         else if (pick < 8) r_d = $urandom_range(TO - 1, 4);
         else if (pick == 8) r_d = TO - 1;
         else r_d = NEVER;
         spurious_en = 1'($urandom_range(1));
         run_tx(r_we, r_size, 1'($urandom_range(1)), r_addr, $urandom, r_d);
      end

      for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
